// File: rtl/cpc_video_pkg.sv
// Shared CPC video definitions: screen modes, pixels per byte and the pen-to-byte bit layout.
package cpc_video_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } mode_t;

    localparam int unsigned PPB_MODE0 = 2;
    localparam int unsigned PPB_MODE1 = 4;
    localparam int unsigned PPB_MODE2 = 8;

    // One queued output byte together with the mode it was packed in.
    typedef struct packed {
        logic       partial;
        mode_t      mode;
        logic [7:0] data;
    } packed_byte_t;

    // Pixels held by one screen byte; mode 3 behaves like mode 0.
    function automatic logic [3:0] pixels_per_byte(input mode_t m);
        case (m)
            MODE1:   return 4'(PPB_MODE1);
            MODE2:   return 4'(PPB_MODE2);
            default: return 4'(PPB_MODE0);
        endcase
    endfunction

    // Bits contributed to the screen byte by pixel idx (0 = leftmost) with pen number pen.
    function automatic logic [7:0] pen_to_bits(input mode_t m, input logic [2:0] idx,
                                              input logic [3:0] pen);
        logic [7:0] bits;
        bits = '0;
        case (m)
            MODE1: bits = 8'({pen[0], 3'b000, pen[1], 3'b000}) >> idx[1:0];
            MODE2: bits = 8'({pen[0], 7'b0000000}) >> idx;
            default: begin
                if (!idx[0])
                    bits = {pen[0], 1'b0, pen[2], 1'b0, pen[1], 1'b0, pen[3], 1'b0};
                else
                    bits = {1'b0, pen[0], 1'b0, pen[2], 1'b0, pen[1], 1'b0, pen[3]};
            end
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small output FIFO for packed screen bytes; space is registered from the next-state count.
module byte_fifo
    import cpc_video_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  packed_byte_t push_data,
    input  logic         pop_ready,
    output logic         head_valid,
    output packed_byte_t head_data,
    output logic         space
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    packed_byte_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    // Occupancy after this edge; push and pop together leave it unchanged.
    always_comb begin
        pop        = head_valid & pop_ready;
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (!push && pop)
            count_next = count - CW'(1);
    end

    // Storage, pointers, count and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            space  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            space <= (count_next != CW'(DEPTH));
        end
    end

endmodule

// File: rtl/pen_byte_packer.sv
// Packs per-pixel pen numbers into CPC screen-memory bytes using the mode-dependent layout.
module pen_byte_packer
    import cpc_video_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] mode,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [3:0] pix_pen,
    input  logic       pix_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [1:0] out_mode,
    output logic       out_partial
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t       state;
    logic [7:0]   acc;
    logic [2:0]   idx;
    mode_t        mode_q;

    mode_t        cur_mode;
    logic [3:0]   ppb;
    logic [7:0]   merged;
    logic         accept;
    logic         complete;
    logic         push;
    packed_byte_t push_data;
    packed_byte_t head;
    logic         space;

    // Current pixel merged into the byte; mode is taken live only on the first pixel.
    always_comb begin
        cur_mode  = (idx == 3'd0) ? mode_t'(mode) : mode_q;
        ppb       = pixels_per_byte(cur_mode);
        accept    = pix_valid & pix_ready;
        merged    = acc | pen_to_bits(cur_mode, idx, pix_pen);
        complete  = (({1'b0, idx}) + 4'd1) == ppb;
        push      = accept & (complete | pix_last);
        push_data.partial = ~complete;
        push_data.mode    = cur_mode;
        push_data.data    = merged;
    end

    // Accumulator FSM: IDLE holds an empty byte, FILL a partially built one.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            mode_q <= MODE0;
        end else if (accept) begin
            if (push) begin
                state <= IDLE;
                acc   <= '0;
                idx   <= '0;
            end else begin
                state  <= FILL;
                acc    <= merged;
                idx    <= idx + 3'd1;
                mode_q <= cur_mode;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  (push_data),
        .pop_ready  (out_ready),
        .head_valid (out_valid),
        .head_data  (head),
        .space      (space)
    );

    assign pix_ready   = space;
    assign out_data    = head.data;
    assign out_mode    = head.mode;
    assign out_partial = head.partial;

endmodule
